// File: rtl/uart_pkg.sv
// Shared encodings for the UART frame parser: FSM states, discard reasons,
// and the index-width helper used by the parser and its payload buffer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_LEN     = 3'd1,
    GET_PAYLOAD = 3'd2,
    GET_CHK     = 3'd3,
    DRAIN       = 3'd4
  } state_t;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buffer.sv
// Payload store for one frame: single write port, single read port with a
// registered read value that feeds the downstream data output directly.
module uart_frame_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array is deliberately not reset; every entry is written
  // before it is read, so a reset would only add area and fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= 8'h00;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind the UART receiver: SYNC, LEN, payload, CHK. Only
// checksum-clean payloads are streamed out on a valid/ready/last interface.
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 87,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = CLKS_PER_BIT * 20
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Data_Valid,
  output logic [7:0] o_Data_Byte,
  output logic       o_Data_Last,
  input  logic       i_Data_Ready,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun,
  output logic       o_Busy
);

  localparam int               IDX_W     = idx_width(MAX_LEN);
  localparam int               CNT_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  state_t           state;
  logic [IDX_W-1:0] len_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       sum;
  logic [CNT_W-1:0] to_cnt;

  logic             waiting;
  logic             timed_out;
  logic             take;
  logic             len_ok;
  logic             chk_ok;
  logic             buf_wr_en;
  logic             buf_rd_en;
  logic [IDX_W-1:0] buf_rd_idx;

  assign waiting   = (state == GET_LEN) || (state == GET_PAYLOAD) || (state == GET_CHK);
  // A strobe in the expiry cycle wins over the timeout.
  assign timed_out = waiting && !i_RX_DV && (to_cnt == CNT_LAST);
  assign take      = o_Data_Valid && i_Data_Ready;
  assign len_ok    = (i_RX_Byte != 8'h00) && (i_RX_Byte <= MAX_LEN_B);
  assign chk_ok    = (state == GET_CHK) && i_RX_DV && (i_RX_Byte == sum);
  assign buf_wr_en = (state == GET_PAYLOAD) && i_RX_DV;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    buf_rd_en  = 1'b0;
    buf_rd_idx = rd_idx;
    if (chk_ok) begin
      buf_rd_en  = 1'b1;
      buf_rd_idx = '0;
    end else if ((state == DRAIN) && take && !o_Data_Last) begin
      buf_rd_en  = 1'b1;
      buf_rd_idx = rd_idx + IDX_W'(1);
    end
  end

  uart_frame_buffer #(
    .DEPTH (MAX_LEN),
    .IDX_W (IDX_W)
  ) u_buffer (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .wr_en   (buf_wr_en),
    .wr_idx  (wr_idx),
    .wr_data (i_RX_Byte),
    .rd_en   (buf_rd_en),
    .rd_idx  (buf_rd_idx),
    .rd_data (o_Data_Byte)
  );

  // The timeout counter holds cycles elapsed since the last strobe, counting
  // the strobe cycle as 0, so it is loaded with 1 when a byte arrives.
  // NOTE: state and outputs use non-blocking assignments so every read below
  // sees the pre-edge value regardless of statement order.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state        <= IDLE;
      len_m1       <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      sum          <= 8'h00;
      to_cnt       <= '0;
      o_Data_Valid <= 1'b0;
      o_Data_Last  <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Err_Code   <= 2'd0;
      o_Overrun    <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      o_Frame_Err <= 1'b0;
      o_Overrun   <= 1'b0;
      to_cnt      <= '0;
      if (timed_out) begin
        state       <= IDLE;
        o_Busy      <= 1'b0;
        o_Frame_Err <= 1'b1;
        o_Err_Code  <= ERR_TIMEOUT;
      end else begin
        case (state)
          IDLE: begin
            if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
              state  <= GET_LEN;
              o_Busy <= 1'b1;
              to_cnt <= CNT_ONE;
            end
          end
          GET_LEN: begin
            if (!i_RX_DV) begin
              to_cnt <= to_cnt + CNT_ONE;
            end else if (len_ok) begin
              len_m1 <= IDX_W'(i_RX_Byte - 8'd1);
              sum    <= i_RX_Byte;
              wr_idx <= '0;
              state  <= GET_PAYLOAD;
              to_cnt <= CNT_ONE;
            end else begin
              state       <= IDLE;
              o_Busy      <= 1'b0;
              o_Frame_Err <= 1'b1;
              o_Err_Code  <= ERR_LEN;
            end
          end
          GET_PAYLOAD: begin
            if (!i_RX_DV) begin
              to_cnt <= to_cnt + CNT_ONE;
            end else begin
              sum    <= sum + i_RX_Byte;
              wr_idx <= wr_idx + IDX_W'(1);
              to_cnt <= CNT_ONE;
              if (wr_idx == len_m1) state <= GET_CHK;
            end
          end
          GET_CHK: begin
            if (!i_RX_DV) begin
              to_cnt <= to_cnt + CNT_ONE;
            end else if (chk_ok) begin
              state        <= DRAIN;
              rd_idx       <= '0;
              o_Data_Valid <= 1'b1;
              o_Data_Last  <= (len_m1 == '0);
            end else begin
              state       <= IDLE;
              o_Busy      <= 1'b0;
              o_Frame_Err <= 1'b1;
              o_Err_Code  <= ERR_CHK;
            end
          end
          DRAIN: begin
            if (i_RX_DV) o_Overrun <= 1'b1;
            if (take) begin
              if (o_Data_Last) begin
                state        <= IDLE;
                o_Busy       <= 1'b0;
                o_Data_Valid <= 1'b0;
                o_Data_Last  <= 1'b0;
              end else begin
                rd_idx      <= rd_idx + IDX_W'(1);
                o_Data_Last <= ((rd_idx + IDX_W'(1)) == len_m1);
              end
            end
          end
          default: begin
            state  <= IDLE;
            o_Busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser: expected payload bytes go into a
// scoreboard queue as frames are sent and are compared as the DUT streams them.
module tb_uart_rx_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 40;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       dv    = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       ready = 1'b1;

  logic       data_valid;
  logic [7:0] data_byte;
  logic       data_last;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  uart_rx_frame_parser #(
    .MAX_LEN      (MAX_LEN),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TIMEOUT)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_RX_DV      (dv),
    .i_RX_Byte    (rx_byte),
    .o_Data_Valid (data_valid),
    .o_Data_Byte  (data_byte),
    .o_Data_Last  (data_last),
    .i_Data_Ready (ready),
    .o_Frame_Err  (frame_err),
    .o_Err_Code   (err_code),
    .o_Overrun    (overrun),
    .o_Busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t       q[$];
  int         errors   = 0;
  int         checks   = 0;
  int         cyc      = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         err_cyc  = -1;
  logic [1:0] err_seen = 2'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && data_valid && ready) begin
      check("data_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("data_byte", 32'(data_byte), 32'(e.b));
        check("data_last", 32'(data_last), 32'(e.last));
      end
    end
    if (frame_err) begin
      ferr_cnt++;
      err_seen = err_code;
      err_cyc  = cyc;
    end
    if (overrun) ovr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    dv      = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    dv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] payload[$], input bit bad_chk, input bit expect_out);
    logic [7:0] sum;
    int         n;
    n   = payload.size();
    sum = 8'(n);
    send(8'hA5);
    send(8'(n));
    foreach (payload[i]) begin
      send(payload[i]);
      sum = sum + payload[i];
    end
    if (expect_out)
      foreach (payload[i]) q.push_back('{b: payload[i], last: (i == n - 1)});
    send(bad_chk ? sum + 8'd1 : sum);
    if (expect_out) check("chk_to_valid", 32'(data_valid), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && q.size() != 0; i++) tick(1);
    check(tag, 32'(q.size()), 32'd0);
    check("valid_low_after_last", 32'(data_valid), 32'd0);
    check("idle_after_last", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_byte"}, 32'(data_byte), 32'd0);
    check({tag, "_last"}, 32'(data_last), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_code"}, 32'(err_code), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] sum;
    int         n;
    int         base;

    // Reset values
    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Good frame, ready tied high
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(pl, 1'b0, 1'b1);
    wait_drain("good_drain");
    check("good_no_ferr", 32'(ferr_cnt), 32'd0);

    // Bad checksum, then a good frame
    send_frame(pl, 1'b1, 1'b0);
    tick(3);
    check("badchk_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("badchk_code", 32'(err_seen), 32'd2);
    check("badchk_busy", 32'(busy), 32'd0);
    pl = '{8'h44, 8'h55};
    send_frame(pl, 1'b0, 1'b1);
    wait_drain("after_badchk_drain");

    // Bad length zero: pulse in the cycle after the LEN strobe, one cycle wide
    send(8'hA5);
    send(8'h00);
    check("badlen0_pulse", 32'(frame_err), 32'd1);
    check("badlen0_code", 32'(err_code), 32'd1);
    tick(1);
    check("badlen0_one_cycle", 32'(frame_err), 32'd0);
    check("badlen0_idle", 32'(busy), 32'd0);

    // Bad length above MAX_LEN
    send(8'hA5);
    send(8'h11);
    tick(5);
    check("badlen17_ferr_cnt", 32'(ferr_cnt), 32'd3);
    check("badlen17_code_held", 32'(err_code), 32'd1);
    check("badlen17_idle", 32'(busy), 32'd0);

    // Timeout: pulse exactly TIMEOUT cycles after the last strobe
    send(8'hA5);
    send(8'h02);
    base = cyc;
    send(8'hAA);
    for (int i = 0; i < TIMEOUT + 20 && ferr_cnt == 3; i++) tick(1);
    check("timeout_seen", 32'(ferr_cnt), 32'd4);
    check("timeout_latency", 32'(err_cyc - base), 32'(TIMEOUT));
    check("timeout_code", 32'(err_seen), 32'd3);
    check("timeout_idle", 32'(busy), 32'd0);

    // A strobe on the expiry cycle is processed instead of timing out
    send(8'hA5);
    send(8'h02);
    base = cyc;
    send(8'hAA);
    while (cyc < base + TIMEOUT - 1) tick(1);
    send(8'hBB);
    sum = 8'h02 + 8'hAA + 8'hBB;
    q.push_back('{b: 8'hAA, last: 1'b0});
    q.push_back('{b: 8'hBB, last: 1'b1});
    send(sum);
    wait_drain("boundary_drain");
    check("boundary_no_timeout", 32'(ferr_cnt), 32'd4);

    // Backpressure with an overrun byte during DRAIN
    check("no_overrun_yet", 32'(ovr_cnt), 32'd0);
    ready = 1'b0;
    pl = '{8'h01, 8'h02};
    send_frame(pl, 1'b0, 1'b1);
    tick(3);
    check("bp_valid", 32'(data_valid), 32'd1);
    check("bp_byte", 32'(data_byte), 32'h01);
    check("bp_last", 32'(data_last), 32'd0);
    send(8'h55);
    tick(95);
    check("bp_overrun_once", 32'(ovr_cnt), 32'd1);
    check("bp_byte_stable", 32'(data_byte), 32'h01);
    check("bp_last_stable", 32'(data_last), 32'd0);
    check("bp_valid_stable", 32'(data_valid), 32'd1);
    ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_no_ferr", 32'(ferr_cnt), 32'd4);

    // Full-length frame exercises the top buffer entry
    pl.delete();
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(i * 13 + 1));
    send_frame(pl, 1'b0, 1'b1);
    wait_drain("maxlen_drain");

    // Reset in the middle of DRAIN after one transfer
    ready = 1'b0;
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(pl, 1'b0, 1'b1);
    tick(2);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    rst   = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_outputs("mid_drain_reset");
    check("one_transfer_before_reset", 32'(q.size()), 32'd2);
    q.delete();
    tick(2);
    ready = 1'b1;
    pl = '{8'h5A, 8'hC3, 8'h0F};
    send_frame(pl, 1'b0, 1'b1);
    wait_drain("post_reset_drain");
    check("reset_no_ferr", 32'(ferr_cnt), 32'd4);

    n = checks;
    $display("Result: errors=%0d of %0d checks", errors, n);
    $finish;
  end

endmodule
